// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Whole packets are granted at a time, optionally followed by an idle gap.
//
// state   | meaning
// IDLE    | no owner, arbitrate between pending requesters
// FETCH   | owner granted, waiting for its next byte
// ISSUE   | start pulse to the transmitter with the latched byte
// WAIT_HI | waiting for the transmitter to report busy
// WAIT_LO | waiting for the transmitter to finish the byte
// GAP     | inter-packet idle time, all readies low
module uart_tx_arbiter #(
    parameter int GAP_CLKS    = 104,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_busy,
    output logic [1:0] grant,
    output logic       pkt_trunc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic [7:0]  MAX_CNT  = 8'(MAX_PKT_LEN);
    localparam logic [15:0] GAP_LOAD = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_b_q, last_b_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] gap_q, gap_d;
    logic        trunc_q, trunc_d;

    logic        own_valid;
    logic [7:0]  own_data;
    logic        own_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_b_q <= 1'b1;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            count_q  <= 8'd0;
            gap_q    <= 16'd0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_b_q <= last_b_d;
            data_q   <= data_d;
            last_q   <= last_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            trunc_q  <= trunc_d;
        end
    end

    always_comb begin
        own_valid = (grant_q[0] & a_valid) | (grant_q[1] & b_valid);
        own_data  = grant_q[1] ? b_data : a_data;
        own_last  = grant_q[1] ? b_last : a_last;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_b_d = last_b_q;
        data_d   = data_q;
        last_d   = last_q;
        count_d  = count_q;
        gap_d    = gap_q;
        trunc_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, A wins only if B was served most recently
                if (a_valid && (!b_valid || last_b_q)) begin
                    grant_d = 2'b01;
                    state_d = FETCH;
                end else if (b_valid) begin
                    grant_d = 2'b10;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (own_valid) begin
                    data_d  = own_data;
                    last_d  = own_last;
                    count_d = count_q + 8'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!uart_busy) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!uart_busy) begin
                    if (!last_q && (count_q < MAX_CNT)) begin
                        state_d = FETCH;
                    end else begin
                        grant_d  = 2'b00;
                        count_d  = 8'd0;
                        last_b_d = grant_q[1];
                        trunc_d  = !last_q;
                        gap_d    = GAP_LOAD;
                        if (GAP_CLKS == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The busy guard only matters if the transmitter is busy for a reason we did not cause
    assign uart_valid = (state_q == ISSUE) && !uart_busy;
    assign uart_data  = data_q;
    assign grant      = grant_q;
    assign pkt_trunc  = trunc_q;
    assign a_ready    = (state_q == FETCH) && grant_q[0];
    assign b_ready    = (state_q == FETCH) && grant_q[1];

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CLKS, default 104, idle clocks inserted after each packet (0 = no gap).
REQ-002 The block SHALL have parameter MAX_PKT_LEN, default 16, the maximum number of bytes per grant (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_data (input, 8 bits), a_valid (input, 1 bit), a_last (input, 1 bit) and a_ready (output, 1 bit) as requester A's byte stream.
REQ-006 The block SHALL have ports b_data, b_valid, b_last and b_ready, identical in direction and width to requester A's, as requester B's byte stream.
REQ-007 The block SHALL have port uart_data, output, 8 bits, the byte presented to the UART transmitter.
REQ-008 The block SHALL have port uart_valid, output, 1 bit, a one-cycle start pulse to the UART transmitter.
REQ-009 The block SHALL have port uart_busy, input, 1 bit, the transmitter busy flag, which rises one cycle after an accepted start pulse.
REQ-010 The block SHALL have port grant, output, 2 bits, one-hot current owner ([0]=A, [1]=B), 00 when unowned.
REQ-011 The block SHALL have port pkt_trunc, output, 1 bit, a one-cycle pulse when a grant ends on MAX_PKT_LEN without last.

Function
REQ-012 The block SHALL implement states IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO and GAP.
REQ-013 In IDLE with exactly one valid high, the block SHALL grant that requester and go to FETCH next cycle.
REQ-014 In IDLE with both valids high, the block SHALL grant the requester not served by the previous grant (round-robin).
REQ-015 The last-served register SHALL reset to B, so A wins the first simultaneous request.
REQ-016 Grant SHALL be registered, SHALL be valid from FETCH through WAIT_LO, and SHALL hold for the whole packet, with no preemption.
REQ-017 x_ready SHALL be combinational: high only in FETCH for the granted requester, and low otherwise.
REQ-018 A transfer SHALL occur when x_valid and x_ready are both high in the same cycle.
REQ-019 On a transfer the block SHALL latch the data byte and the last flag, increment the 8-bit byte count, and go to ISSUE.
REQ-020 In FETCH with the owner's valid low, the block SHALL wait indefinitely; there is no timeout.
REQ-021 In ISSUE, uart_data SHALL hold the latched byte and uart_valid SHALL be 1 for exactly one cycle; the next state is WAIT_HI.
REQ-022 uart_data SHALL remain stable from ISSUE until the next ISSUE.
REQ-023 WAIT_HI SHALL advance to WAIT_LO on uart_busy=1.
REQ-024 WAIT_LO SHALL wait for uart_busy=0 and then go to FETCH if the latched last=0 and count<MAX_PKT_LEN.
REQ-025 WAIT_LO SHALL otherwise end the grant: grant->00, count->0, last-served updated, and next state GAP (or IDLE if GAP_CLKS=0).
REQ-026 pkt_trunc SHALL pulse for one cycle, coincident with the end of the grant, when the grant ends on count==MAX_PKT_LEN with latched last=0.
REQ-027 When count reaches MAX_PKT_LEN with last=1, the block SHALL treat it as a normal end and SHALL NOT pulse pkt_trunc.
REQ-028 GAP SHALL count GAP_CLKS cycles with all readies low, then go to IDLE.
REQ-029 Requests arriving during GAP SHALL be held off and arbitrated in IDLE.
REQ-030 Valid or last on a non-granted requester SHALL be ignored.
REQ-031 The block SHALL never issue uart_valid while uart_busy=1.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, uart_valid=0, uart_data=00h, grant=00, pkt_trunc=0, count=0, gap counter=0 and last-served=B.
REQ-033 a_ready and b_ready SHALL be 0 while in reset.
REQ-034 Reset asserted mid-packet SHALL abandon the packet with no further uart_valid.
REQ-035 After release of reset, operation SHALL resume from IDLE on the first rising edge.

Verification
REQ-036 The bench SHALL cover: A sends 3 bytes 11h,22h,33h (last on 33h) into a uart_tx model -> three uart_valid pulses, one per busy cycle; grant=01 throughout; GAP_CLKS idle clocks follow.
REQ-037 The bench SHALL cover: a_valid and b_valid rise in the same cycle after reset -> A granted first; B granted on the next IDLE; then A again if both still request.
REQ-038 The bench SHALL cover: B streams 20 bytes with last never set, MAX_PKT_LEN=16 -> exactly 16 bytes sent, pkt_trunc pulses once, and A (requesting) is granted next.
REQ-039 The bench SHALL cover: the owner drops valid for 50 cycles mid-packet while the other requester is valid -> grant held, no uart_valid during the stall, and resumption on valid.
REQ-040 The bench SHALL cover: rst_n pulsed low during WAIT_LO of byte 2 -> outputs at reset values asynchronously, no further uart_valid, and a fresh arbitration after release.
REQ-041 The bench SHALL cover: GAP_CLKS=0 with back-to-back single-byte packets from A and B -> IDLE follows WAIT_LO directly and grants alternate A,B,A,B.
